// File: rtl/modport_counter_if.sv
// Interface bundling the counter's control inputs and outputs, with a
// driver-side modport for stimulus and a dut-side modport for the counter.
interface count_ifc #(
    parameter int WIDTH = 4
) (
    input logic CLK
);
    logic             MR;
    logic             Load;
    logic             Enable;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] Q;
    logic             TC;

    modport driver (
        input  CLK,
        output MR,
        output Load,
        output Enable,
        output P,
        input  Q,
        input  TC
    );

    modport dut (
        input  CLK,
        input  MR,
        input  Load,
        input  Enable,
        input  P,
        output Q,
        output TC
    );
endinterface

// File: rtl/modport_counter.sv
// Presettable binary up-counter (74x163 style) with synchronous master reset
// and terminal count. Define MODPORT_COUNTER_SAT_EN to saturate at all-ones.
module modport_counter_core #(
    parameter int WIDTH = 4
) (
    count_ifc.dut bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] countReg;
    logic             atMax;

    assign atMax = (countReg == ALL_ONES);

    // Reset beats load, load beats increment; otherwise the count holds.
    always_ff @(posedge bus.CLK) begin
        if (bus.MR) begin
            countReg <= '0;
        end else if (bus.Load) begin
            countReg <= bus.P;
        end else if (bus.Enable) begin
`ifdef MODPORT_COUNTER_SAT_EN
            if (!atMax) begin
                countReg <= countReg + 1'b1;
            end
`else
            countReg <= countReg + 1'b1;
`endif
        end
    end

    // TC is purely combinational so a cascaded stage sees it in the same cycle.
    assign bus.TC = bus.Enable & atMax & ~bus.MR & ~bus.Load;
    assign bus.Q  = countReg;
endmodule

module modport_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic [WIDTH-1:0] P,
    input  logic             Load,
    input  logic             Enable,
    output logic [WIDTH-1:0] Q,
    output logic             TC
);
    count_ifc #(.WIDTH(WIDTH)) bus (.CLK(CLK));

    assign bus.MR     = MR;
    assign bus.P      = P;
    assign bus.Load   = Load;
    assign bus.Enable = Enable;

    modport_counter_core #(.WIDTH(WIDTH)) core (.bus(bus.dut));

    assign Q  = bus.Q;
    assign TC = bus.TC;
endmodule

// File: tb/tb_modport_counter.sv
// Directed self-checking bench for modport_counter (WIDTH=4); honours
// MODPORT_COUNTER_SAT_EN when choosing wrap-point expectations.
module tb_modport_counter;
    logic       CLK;
    logic       MR;
    logic [3:0] P;
    logic       Load;
    logic       Enable;
    logic [3:0] Q;
    logic       TC;

    int testsRun;
    int testsFailed;

    modport_counter #(.WIDTH(4)) dut (
        .CLK(CLK),
        .MR(MR),
        .P(P),
        .Load(Load),
        .Enable(Enable),
        .Q(Q),
        .TC(TC)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one rising edge and settle 1 unit past it before driving/sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        MR = 1'b0; Load = 1'b1; Enable = 1'b0; P = 4'h9;
        tick();
        testsRun++;
        if (Q !== 4'h9) begin
            testsFailed++;
            $display("[TB] FAIL reset_preload: Q=%0h expected %0h", Q, 4'h9);
        end
        MR = 1'b1; Load = 1'b0; Enable = 1'b1;
        tick();
        testsRun++;
        if (Q !== 4'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_clear: Q=%0h expected %0h", Q, 4'h0);
        end
        testsRun++;
        if (TC !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_tc: TC=%0b expected 0", TC);
        end
        MR = 1'b0;
        tick();
        testsRun++;
        if (Q !== 4'h1) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: Q=%0h expected %0h", Q, 4'h1);
        end
    endtask

    task automatic test_count_hold();
        MR = 1'b1; Load = 1'b0; Enable = 1'b0;
        tick();
        MR = 1'b0; Enable = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        testsRun++;
        if (Q !== 4'h5) begin
            testsFailed++;
            $display("[TB] FAIL count5: Q=%0h expected %0h", Q, 4'h5);
        end
        Enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++;
            if (Q !== 4'h5) begin
                testsFailed++;
                $display("[TB] FAIL hold%0d: Q=%0h expected %0h", i, Q, 4'h5);
            end
        end
        // Pulse Load between edges; it must not be sampled.
        Load = 1'b1; P = 4'hC;
        #2;
        Load = 1'b0;
        Enable = 1'b1;
        tick();
        testsRun++;
        if (Q !== 4'h6) begin
            testsFailed++;
            $display("[TB] FAIL count6: Q=%0h expected %0h", Q, 4'h6);
        end
    endtask

    task automatic test_load_priority();
        Load = 1'b1; Enable = 1'b0; P = 4'h3;
        tick();
        P = 4'b0111; Load = 1'b1; Enable = 1'b1;
        tick();
        testsRun++;
        if (Q !== 4'h7) begin
            testsFailed++;
            $display("[TB] FAIL load_over_enable: Q=%0h expected %0h", Q, 4'h7);
        end
        Load = 1'b0;
        tick();
        testsRun++;
        if (Q !== 4'h8) begin
            testsFailed++;
            $display("[TB] FAIL count_after_load: Q=%0h expected %0h", Q, 4'h8);
        end
    endtask

    task automatic test_wrap_tc();
        logic [3:0] wrapQ;
        logic       wrapTc;
`ifdef MODPORT_COUNTER_SAT_EN
        wrapQ = 4'hF; wrapTc = 1'b1;
`else
        wrapQ = 4'h0; wrapTc = 1'b0;
`endif
        P = 4'hE; Load = 1'b1; Enable = 1'b1;
        tick();
        Load = 1'b0;
        testsRun++;
        if (TC !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL tc_at_E: TC=%0b expected 0", TC);
        end
        tick();
        testsRun++;
        if (Q !== 4'hF) begin
            testsFailed++;
            $display("[TB] FAIL reach_F: Q=%0h expected %0h", Q, 4'hF);
        end
        testsRun++;
        if (TC !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL tc_at_F: TC=%0b expected 1", TC);
        end
        Enable = 1'b0;
        #1;
        testsRun++;
        if (TC !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL tc_no_enable: TC=%0b expected 0", TC);
        end
        Load = 1'b1; Enable = 1'b1; P = 4'h2;
        #1;
        testsRun++;
        if (TC !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL tc_load_masks: TC=%0b expected 0", TC);
        end
        Load = 1'b0;
        tick();
        testsRun++;
        if (Q !== wrapQ) begin
            testsFailed++;
            $display("[TB] FAIL wrap_q: Q=%0h expected %0h", Q, wrapQ);
        end
        testsRun++;
        if (TC !== wrapTc) begin
            testsFailed++;
            $display("[TB] FAIL wrap_tc: TC=%0b expected %0b", TC, wrapTc);
        end
    endtask

    task automatic test_reset_priority();
        P = 4'hF; Load = 1'b1; Enable = 1'b0; MR = 1'b0;
        tick();
        MR = 1'b1; Load = 1'b1; P = 4'hA; Enable = 1'b1;
        #1;
        testsRun++;
        if (TC !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL tc_mr_masks: TC=%0b expected 0", TC);
        end
        tick();
        testsRun++;
        if (Q !== 4'h0) begin
            testsFailed++;
            $display("[TB] FAIL mr_over_all: Q=%0h expected %0h", Q, 4'h0);
        end
        testsRun++;
        if (TC !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mr_tc: TC=%0b expected 0", TC);
        end
        MR = 1'b0; Load = 1'b0; Enable = 1'b0;
    endtask

    task automatic test_sequence();
        logic [3:0] expSeq [9];
        expSeq = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h5, 4'h5, 4'h7};
        P = 4'h7; Load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            MR     = (i == 0);
            Enable = (i >= 1 && i <= 5);
            Load   = (i == 8);
            tick();
            testsRun++;
            if (Q !== expSeq[i]) begin
                testsFailed++;
                $display("[TB] FAIL seq%0d: Q=%0h expected %0h", i, Q, expSeq[i]);
            end
        end
        MR = 1'b0; Load = 1'b0; Enable = 1'b0;
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        MR = 1'b0; P = 4'h0; Load = 1'b0; Enable = 1'b0;
        test_reset();
        test_count_hold();
        test_load_priority();
        test_wrap_tc();
        test_reset_priority();
        test_sequence();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
